sdrc_lite_init_ref_seq: RTL and testbench
=========================================

Name: sdrc_lite_init_ref_seq

Overview:
- Power-up initialisation and auto-refresh sequencer for the sdrc_lite SDR SDRAM controller.
- Consumes the MCB timing parameters (tRP, tRFC, tMRD), mode register value and refresh interval.
- Drives its own SDRAM command slot into the controller's command mux: a PRECHARGE-ALL / 2×AUTO-REFRESH / LOAD-MODE init sequence, then periodic refreshes arbitrated via req/ack with the read/write engine.

Parameters:
- SDR_A_W, 13, SDRAM address width.
- R_REF_I_CNT_W, 12, refresh interval counter width.
- INIT_W, 16, power-up wait counter width.
- CtINIT, 20000, power-up wait in clocks (200 us at 100 MHz).
- CtRPm1, 2, tRP clocks minus 1.
- CtRFCm1, 6, tRFC clocks minus 1.
- CtMRDm1, 1, tMRD clocks minus 1.
- INIT_AREF_NUM, 2, AUTO-REFRESH count during init.

Ports:
- clk  in  1  controller clock.
- rst  in  1  synchronous active-high reset.
- mode_rg_val  in  SDR_A_W  value driven on address during LOAD MODE.
- ref_intv_num  in  R_REF_I_CNT_W  clocks per refresh; 0 = refresh disabled.
- ref_ack  in  1  arbiter grant: banks idle, bus yielded.
- init_done  out  1  level, init sequence complete.
- ref_req  out  1  refresh pending, request for bus.
- seq_own  out  1  this block owns the SDRAM command bus.
- cmd_rcw  out  3  {ras_n,cas_n,we_n}: NOP 111, PALL 010, AREF 001, LMR 000.
- cmd_addr  out  SDR_A_W  address; bit10=1 with PALL, mode_rg_val with LMR, else 0.
- ref_done  out  1  one-cycle pulse after tRFC of each post-init refresh.

Behaviour:
- Reset values: init_done=0, ref_req=0, seq_own=1, cmd_rcw=111, cmd_addr=0, ref_done=0. FSM→WAIT, wait counter loads CtINIT, pend=0.
- All outputs are registered. Each command (non-NOP) lasts exactly one cycle; NOP otherwise.
- rst asserted mid-sequence restarts from WAIT and drops init_done. No partial command is held.

Init FSM:
- WAIT: counts CtINIT cycles.
- PALL: issues PALL, next command ≥CtRPm1+1 cycles later (T_RP).
- AREF: issues AREF, then T_RFC for CtRFCm1+1 cycles.
- Repeats AREF INIT_AREF_NUM times (aref counter).
- LMR: issues LMR, then T_MRD for CtMRDm1+1 cycles.
- IDLE: init_done=1 and seq_own=0, both in the same cycle.
- Cycle spacing rule: if command X is on cmd_rcw in cycle t, the next command appears in cycle t+Cm1+1 exactly.

Refresh timer:
- Starts at the cycle init_done rises; counts 0..ref_intv_num-1.
- Each wrap increments pend (3 bits, saturates at 7).
- ref_intv_num==0: counter held at 0, no increments.
- ref_intv_num change takes effect at the next wrap.

Refresh FSM (post-init):
- IDLE with pend>0 → REQ: ref_req=1, held until ref_ack sampled 1 in REQ.
- Next cycle → R_PALL: seq_own=1, ref_req=0, issue PALL; then T_RP.
- R_AREF: issue AREF, pend decrements; then T_RFC.
- After T_RFC: ref_done pulses and seq_own drops in the same cycle. Return to IDLE; REQ is re-entered next cycle if pend>0.
- A timer wrap coinciding with the AREF decrement leaves pend unchanged.
- ref_ack outside REQ is ignored.

Test Plan:
- Init timing: CtINIT=10, CtRPm1=1, CtRFCm1=4, CtMRDm1=1, mode_rg_val=13'h032, rst released at cycle 0 → commands are:
  - PALL (addr bit10=1) at cycle 10;
  - AREF at 12 and 17;
  - LMR (addr 032) at 22;
  - init_done=1 and seq_own=0 at 24.
- Single refresh: ref_intv_num=50, ref_ack tied 1 → ref_req rises 1 cycle after the first wrap. Then:
  - PALL 1 cycle after ack;
  - AREF 2 cycles after PALL;
  - ref_done 5 cycles after AREF;
  - seq_own high from PALL through ref_done.
- Ack stall / backlog: ref_ack=0 for 400 cycles with ref_intv_num=50 → pend saturates at 7 and ref_req stays high. After release, exactly 7 back-to-back refreshes, each PALL/AREF pair, 7 ref_done pulses, then ref_req=0.
- Coincident tick: arrange a timer wrap in the same cycle as AREF with pend=1 → pend stays 1 and a second refresh follows.
- Disable: ref_intv_num=0 after init → no ref_req for 1000 cycles, cmd_rcw stays 111.
- Reset mid-operation: assert rst during T_RFC of the 2nd init AREF → next cycle outputs equal reset values. After release, the full sequence restarts, with PALL at cycle CtINIT after release.

Source files
------------

// File: rtl/sdrc_lite_init_ref_seq.sv
// Power-up init (PALL / AREF x N / LMR) and periodic auto-refresh sequencer
// for the sdrc_lite controller; owns its own command slot in the command mux.
module sdrc_lite_init_ref_seq #(
    parameter int unsigned SDR_A_W       = 13,
    parameter int unsigned R_REF_I_CNT_W = 12,
    parameter int unsigned INIT_W        = 16,
    parameter int unsigned CtINIT        = 20000,
    parameter int unsigned CtRPm1        = 2,
    parameter int unsigned CtRFCm1       = 6,
    parameter int unsigned CtMRDm1       = 1,
    parameter int unsigned INIT_AREF_NUM = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SDR_A_W-1:0]       mode_rg_val,
    input  logic [R_REF_I_CNT_W-1:0] ref_intv_num,
    input  logic                     ref_ack,
    output logic                     init_done,
    output logic                     ref_req,
    output logic                     seq_own,
    output logic [2:0]               cmd_rcw,
    output logic [SDR_A_W-1:0]       cmd_addr,
    output logic                     ref_done
);

    localparam int unsigned AREF_W = (INIT_AREF_NUM < 1) ? 1 : $clog2(INIT_AREF_NUM + 1);
    localparam int unsigned PEND_W = 3;

    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_PALL = 3'b010;
    localparam logic [2:0] CMD_AREF = 3'b001;
    localparam logic [2:0] CMD_LMR  = 3'b000;

    localparam logic [SDR_A_W-1:0] ADDR_ALL_BANKS = SDR_A_W'(1024);

    typedef enum logic [2:0] {
        S_WAIT, S_I_RP, S_I_RFC, S_I_MRD, S_IDLE, S_REQ, S_R_RP, S_R_RFC
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [INIT_W-1:0]        r_cnt;
    logic [INIT_W-1:0]        w_cnt_nxt;
    logic [AREF_W-1:0]        r_aref;
    logic [AREF_W-1:0]        w_aref_nxt;
    logic [2:0]               w_cmd_nxt;
    logic                     w_cnt_zero;
    logic                     w_pend_dec;

    logic [R_REF_I_CNT_W-1:0] r_tmr;
    logic [R_REF_I_CNT_W-1:0] r_intv;
    logic [PEND_W-1:0]        r_pend;
    logic                     w_tick;

    logic                     w_init_done_nxt;
    logic                     w_ref_req_nxt;
    logic                     w_seq_own_nxt;
    logic                     w_ref_done_nxt;
    logic [SDR_A_W-1:0]       w_addr_nxt;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_pend_dec = (r_state == S_R_RP) && w_cnt_zero;

    // State register with its spacing counter and init AREF counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT;
            r_cnt   <= INIT_W'(CtINIT);
            r_aref  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_aref  <= w_aref_nxt;
        end
    end

    // Next state; a command is issued on the transition, its spacing loaded into r_cnt
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - INIT_W'(1);
        w_aref_nxt  = r_aref;
        w_cmd_nxt   = CMD_NOP;
        case (r_state)
            S_WAIT: if (w_cnt_zero) begin
                w_cmd_nxt   = CMD_PALL;
                w_cnt_nxt   = INIT_W'(CtRPm1);
                w_state_nxt = S_I_RP;
            end
            S_I_RP: if (w_cnt_zero) begin
                w_cmd_nxt   = CMD_AREF;
                w_cnt_nxt   = INIT_W'(CtRFCm1);
                w_aref_nxt  = r_aref + AREF_W'(1);
                w_state_nxt = S_I_RFC;
            end
            S_I_RFC: if (w_cnt_zero) begin
                if (r_aref == AREF_W'(INIT_AREF_NUM)) begin
                    w_cmd_nxt   = CMD_LMR;
                    w_cnt_nxt   = INIT_W'(CtMRDm1);
                    w_state_nxt = S_I_MRD;
                end else begin
                    w_cmd_nxt  = CMD_AREF;
                    w_cnt_nxt  = INIT_W'(CtRFCm1);
                    w_aref_nxt = r_aref + AREF_W'(1);
                end
            end
            S_I_MRD: if (w_cnt_zero) w_state_nxt = S_IDLE;
            S_IDLE:  if (r_pend != '0) w_state_nxt = S_REQ;
            S_REQ: if (ref_ack) begin
                w_cmd_nxt   = CMD_PALL;
                w_cnt_nxt   = INIT_W'(CtRPm1);
                w_state_nxt = S_R_RP;
            end
            S_R_RP: if (w_cnt_zero) begin
                w_cmd_nxt   = CMD_AREF;
                w_cnt_nxt   = INIT_W'(CtRFCm1);
                w_state_nxt = S_R_RFC;
            end
            S_R_RFC: if (w_cnt_zero) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_WAIT;
        endcase
    end

    // Output decode from the state being entered, registered below
    always_comb begin
        w_init_done_nxt = 1'b0;
        w_ref_req_nxt   = 1'b0;
        w_seq_own_nxt   = 1'b1;
        w_addr_nxt      = '0;
        case (w_state_nxt)
            S_IDLE: begin
                w_init_done_nxt = 1'b1;
                w_seq_own_nxt   = 1'b0;
            end
            S_REQ: begin
                w_init_done_nxt = 1'b1;
                w_seq_own_nxt   = 1'b0;
                w_ref_req_nxt   = 1'b1;
            end
            S_R_RP, S_R_RFC: w_init_done_nxt = 1'b1;
            default: ;
        endcase
        w_ref_done_nxt = (r_state == S_R_RFC) && (w_state_nxt == S_IDLE);
        if (w_cmd_nxt == CMD_PALL) w_addr_nxt = ADDR_ALL_BANKS;
        if (w_cmd_nxt == CMD_LMR)  w_addr_nxt = mode_rg_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_done <= 1'b0;
            ref_req   <= 1'b0;
            seq_own   <= 1'b1;
            cmd_rcw   <= CMD_NOP;
            cmd_addr  <= '0;
            ref_done  <= 1'b0;
        end else begin
            init_done <= w_init_done_nxt;
            ref_req   <= w_ref_req_nxt;
            seq_own   <= w_seq_own_nxt;
            cmd_rcw   <= w_cmd_nxt;
            cmd_addr  <= w_addr_nxt;
            ref_done  <= w_ref_done_nxt;
        end
    end

    assign w_tick = init_done && (r_intv != '0) && (r_tmr == r_intv - R_REF_I_CNT_W'(1));

    // Refresh interval timer; the interval is re-latched only at a wrap or while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr  <= '0;
            r_intv <= '0;
            r_pend <= '0;
        end else begin
            if (!init_done || (r_intv == '0) || w_tick) begin
                r_tmr  <= '0;
                r_intv <= ref_intv_num;
            end else begin
                r_tmr  <= r_tmr + R_REF_I_CNT_W'(1);
            end
            case ({w_tick, w_pend_dec})
                2'b10:   if (r_pend != '1) r_pend <= r_pend + PEND_W'(1);
                2'b01:   r_pend <= r_pend - PEND_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdrc_lite_init_ref_seq.sv
// Randomized bench: event-timeline model of the init/refresh sequencer,
// checked every cycle, plus literal timing checks for the directed scenarios.
module tb_sdrc_lite_init_ref_seq;

    localparam int A_W     = 13;
    localparam int I_W     = 12;
    localparam int CT_INIT = 10;
    localparam int RP      = 1;
    localparam int RFC     = 4;
    localparam int MRD     = 1;
    localparam int NAREF   = 2;

    localparam int T_P  = CT_INIT;
    localparam int T_A1 = T_P + RP + 1;
    localparam int T_L  = T_A1 + NAREF * (RFC + 1);
    localparam int T_I  = T_L + MRD + 1;

    localparam logic [2:0] NOP = 3'b111, PALL = 3'b010, AREF = 3'b001, LMR = 3'b000;

    logic           clk;
    logic           rst;
    logic [A_W-1:0] mode_rg_val;
    logic [I_W-1:0] ref_intv_num;
    logic           ref_ack;
    logic           init_done, ref_req, seq_own, ref_done;
    logic [2:0]     cmd_rcw;
    logic [A_W-1:0] cmd_addr;

    sdrc_lite_init_ref_seq #(
        .SDR_A_W(A_W), .R_REF_I_CNT_W(I_W), .INIT_W(16), .CtINIT(CT_INIT),
        .CtRPm1(RP), .CtRFCm1(RFC), .CtMRDm1(MRD), .INIT_AREF_NUM(NAREF)
    ) dut (
        .clk(clk), .rst(rst), .mode_rg_val(mode_rg_val), .ref_intv_num(ref_intv_num),
        .ref_ack(ref_ack), .init_done(init_done), .ref_req(ref_req), .seq_own(seq_own),
        .cmd_rcw(cmd_rcw), .cmd_addr(cmd_addr), .ref_done(ref_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: cycle index since reset release plus refresh timeline
    int             m_k = -1;
    int             m_next_wrap = 0;
    bit             m_wrap_en = 0;
    int             m_pend = 0;
    bit             m_req = 0;
    bit             m_busy = 0;
    int             m_a = 0;
    logic           e_init_done = 0, e_ref_req = 0, e_seq_own = 1, e_ref_done = 0;
    logic [2:0]     e_cmd = NOP;
    logic [A_W-1:0] e_addr = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d, t=%0t)", name, act, exp, m_k, $time);
        end
    endfunction

    function automatic void load_intv();
        if (ref_intv_num != '0) begin
            m_wrap_en   = 1'b1;
            m_next_wrap = m_k + int'(ref_intv_num);
        end else begin
            m_wrap_en = 1'b0;
        end
    endfunction

    function automatic void model_step();
        bit wrap;
        bit dec;
        int off;
        wrap = 1'b0;
        dec  = 1'b0;
        if (rst) begin
            m_k = -1;
            e_init_done = 0; e_ref_req = 0; e_seq_own = 1; e_ref_done = 0;
            e_cmd = NOP; e_addr = '0;
            m_pend = 0; m_req = 0; m_busy = 0; m_wrap_en = 0;
        end else begin
            m_k++;
            e_cmd = NOP; e_addr = '0; e_ref_done = 0; e_ref_req = 0;
            if (m_k < T_I) begin
                e_init_done = 0;
                e_seq_own   = 1;
                if (m_k == T_P) begin
                    e_cmd = PALL; e_addr = 13'h0400;
                end else if (m_k >= T_A1 && m_k < T_L && ((m_k - T_A1) % (RFC + 1)) == 0) begin
                    e_cmd = AREF;
                end else if (m_k == T_L) begin
                    e_cmd = LMR; e_addr = mode_rg_val;
                end
            end else begin
                e_init_done = 1;
                e_seq_own   = 0;
                if (m_k == T_I || !m_wrap_en) begin
                    load_intv();
                end else if (m_k == m_next_wrap) begin
                    wrap = 1'b1;
                    load_intv();
                end
                if (m_busy) begin
                    off = m_k - m_a;
                    e_seq_own = 1;
                    if (off == RP + 1) begin
                        e_cmd = AREF; dec = 1'b1;
                    end
                    if (off == RP + 1 + RFC + 1) begin
                        e_ref_done = 1; e_seq_own = 0; m_busy = 0;
                    end
                end else if (m_req) begin
                    if (ref_ack) begin
                        m_req = 0; m_busy = 1; m_a = m_k;
                        e_cmd = PALL; e_addr = 13'h0400; e_seq_own = 1;
                    end else begin
                        e_ref_req = 1;
                    end
                end else if (m_pend > 0) begin
                    m_req = 1; e_ref_req = 1;
                end
                if (wrap && !dec && m_pend < 7) m_pend++;
                if (dec && !wrap) m_pend--;
            end
        end
    endfunction

    // Compare process: inputs are stable here, matching what the DUT sampled
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            chk("init_done", 32'(init_done), 32'(e_init_done));
            chk("ref_req",   32'(ref_req),   32'(e_ref_req));
            chk("seq_own",   32'(seq_own),   32'(e_seq_own));
            chk("cmd_rcw",   32'(cmd_rcw),   32'(e_cmd));
            chk("cmd_addr",  32'(cmd_addr),  32'(e_addr));
            chk("ref_done",  32'(ref_done),  32'(e_ref_done));
        end
    end

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_k(input int t);
        int n;
        n = 0;
        while (m_k != t && n < 3000) begin
            next_cyc();
            n++;
        end
        if (m_k != t) begin
            total++;
            bad++;
            $display("FAIL wait_k: cycle %0d never reached (at %0d)", t, m_k);
        end
    endtask

    task automatic check_init_literals();
        wait_k(T_P);  chk("lit_pall", 32'(cmd_rcw), 32'(3'b010)); chk("lit_pall_a", 32'(cmd_addr), 32'h400);
        wait_k(12);   chk("lit_aref1", 32'(cmd_rcw), 32'(3'b001));
        wait_k(17);   chk("lit_aref2", 32'(cmd_rcw), 32'(3'b001));
        wait_k(22);   chk("lit_lmr", 32'(cmd_rcw), 32'(3'b000)); chk("lit_lmr_a", 32'(cmd_addr), 32'h032);
        wait_k(23);   chk("lit_pre_done", 32'(init_done), 32'd0);
        wait_k(24);   chk("lit_done", 32'(init_done), 32'd1); chk("lit_own0", 32'(seq_own), 32'd0);
    endtask

    initial begin
        int n_done, n_pall, n_aref, n_req, n_cmd;
        rst = 1'b1; ref_ack = 1'b1; ref_intv_num = 12'd50; mode_rg_val = 13'h032;
        repeat (3) next_cyc();
        rst = 1'b0;
        check_init_literals();

        // First refresh with ack tied high
        wait_k(74);  chk("lit_noreq", 32'(ref_req), 32'd0);
        wait_k(75);  chk("lit_req", 32'(ref_req), 32'd1);
        wait_k(76);  chk("lit_rpall", 32'(cmd_rcw), 32'(3'b010)); chk("lit_rown", 32'(seq_own), 32'd1);
                     chk("lit_req0", 32'(ref_req), 32'd0);
        wait_k(78);  chk("lit_raref", 32'(cmd_rcw), 32'(3'b001));
        wait_k(82);  chk("lit_own_hold", 32'(seq_own), 32'd1);
        wait_k(83);  chk("lit_rdone", 32'(ref_done), 32'd1); chk("lit_own_drop", 32'(seq_own), 32'd0);

        // Wrap coinciding with the AREF of the following refresh
        wait_k(123); ref_intv_num = 12'd4;
        wait_k(124); ref_intv_num = 12'd50;
        wait_k(128); chk("lit_coin_aref", 32'(cmd_rcw), 32'(3'b001));
        wait_k(134); chk("lit_coin_req", 32'(ref_req), 32'd1);
        wait_k(137); chk("lit_coin_aref2", 32'(cmd_rcw), 32'(3'b001));

        // Randomized traffic, with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            ref_ack = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 5))
                    0:       ref_intv_num = '0;
                    1:       ref_intv_num = 12'($urandom_range(1, 3));
                    default: ref_intv_num = 12'($urandom_range(5, 80));
                endcase
            end
            mode_rg_val = 13'($urandom);
            rst = (i == 1500);
            next_cyc();
        end
        rst = 1'b0;

        // Ack stall backlog, then disable the timer
        ref_intv_num = 12'd50; ref_ack = 1'b0;
        repeat (400) next_cyc();
        ref_intv_num = '0;
        repeat (60) next_cyc();
        chk("lit_stall_req", 32'(ref_req), 32'd1);
        ref_ack = 1'b1;
        n_done = 0; n_pall = 0; n_aref = 0;
        for (int i = 0; i < 150; i++) begin
            next_cyc();
            if (ref_done) n_done++;
            if (cmd_rcw == PALL) n_pall++;
            if (cmd_rcw == AREF) n_aref++;
        end
        chk("lit_backlog_done", 32'(n_done), 32'd7);
        chk("lit_backlog_pall", 32'(n_pall), 32'd7);
        chk("lit_backlog_aref", 32'(n_aref), 32'd7);
        chk("lit_backlog_req0", 32'(ref_req), 32'd0);
        n_req = 0; n_cmd = 0;
        for (int i = 0; i < 1000; i++) begin
            next_cyc();
            if (ref_req) n_req++;
            if (cmd_rcw != NOP) n_cmd++;
        end
        chk("lit_dis_req", 32'(n_req), 32'd0);
        chk("lit_dis_cmd", 32'(n_cmd), 32'd0);

        // Reset during tRFC of the second init AREF
        ref_intv_num = 12'd50; mode_rg_val = 13'h032;
        rst = 1'b1; next_cyc(); next_cyc(); rst = 1'b0;
        wait_k(19);
        chk("lit_mid_own", 32'(seq_own), 32'd1);
        rst = 1'b1; next_cyc();
        chk("lit_rst_done", 32'(init_done), 32'd0);
        chk("lit_rst_req", 32'(ref_req), 32'd0);
        chk("lit_rst_own", 32'(seq_own), 32'd1);
        chk("lit_rst_cmd", 32'(cmd_rcw), 32'(3'b111));
        chk("lit_rst_addr", 32'(cmd_addr), 32'd0);
        chk("lit_rst_rdone", 32'(ref_done), 32'd0);
        rst = 1'b0;
        check_init_literals();
        repeat (100) next_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
